// File: rtl/fir_mac_scheduler.sv
// Stereo FIR controller: one shared signed multiply-accumulate unit, round-robin between the
// left and right channels, per-channel circular sample history, idle-only coefficient writes.
module fir_mac_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned TAPS       = 16,
  localparam int unsigned PTR_W     = $clog2(TAPS),
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] s_left_data,
  input  logic                         s_left_valid,
  output logic                         s_left_ready,
  input  logic signed [DATA_WIDTH-1:0] s_right_data,
  input  logic                         s_right_valid,
  output logic                         s_right_ready,
  output logic signed [ACC_WIDTH-1:0]  m_data,
  output logic                         m_channel,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic                         coef_wr_en,
  input  logic [PTR_W-1:0]             coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
  output logic                         busy
);

  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam logic [PTR_W:0] K_LAST = TAPS[PTR_W:0];

  typedef enum logic [1:0] {StIdle, StLoad, StMac, StOut} state_e;

  state_e                       r_state;
  state_e                       w_state_d;
  logic                         r_ch;
  logic signed [DATA_WIDTH-1:0] r_sample;
  logic signed [DATA_WIDTH-1:0] r_hist [2][TAPS];
  logic [PTR_W-1:0]             r_wptr [2];
  logic signed [COEF_WIDTH-1:0] r_coef [TAPS];
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [PROD_W-1:0]     r_prod;
  logic [PTR_W:0]               r_k;
  // Set when left was served last, so a tie goes to right; zero after reset lets left win.
  logic                         r_prio_right;
  logic signed [ACC_WIDTH-1:0]  r_m_data;
  logic                         r_m_channel;
  logic                         r_m_valid;

  logic                         w_idle;
  logic                         w_grant_left;
  logic                         w_grant_right;
  logic                         w_accept;
  logic                         w_last_mac;
  logic [PTR_W-1:0]             w_tap_idx;
  logic signed [DATA_WIDTH-1:0] w_hist_tap;
  logic signed [COEF_WIDTH-1:0] w_coef_tap;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;

  // Readies are gated by reset so nothing is offered while state is being cleared.
  assign w_idle        = (r_state == StIdle) && !reset;
  assign w_grant_left  = w_idle && s_left_valid && (!s_right_valid || !r_prio_right);
  assign w_grant_right = w_idle && s_right_valid && (!s_left_valid || r_prio_right);
  assign w_accept      = w_grant_left || w_grant_right;

  assign w_last_mac = (r_k == K_LAST);
  assign w_tap_idx  = r_wptr[r_ch] - r_k[PTR_W-1:0];
  assign w_hist_tap = r_hist[r_ch][w_tap_idx];
  assign w_coef_tap = r_coef[r_k[PTR_W-1:0]];
  assign w_prod     = PROD_W'(w_coef_tap) * PROD_W'(w_hist_tap);
  assign w_prod_ext = ACC_WIDTH'(r_prod);

  assign s_left_ready  = w_grant_left;
  assign s_right_ready = w_grant_right;
  assign m_data        = r_m_data;
  assign m_channel     = r_m_channel;
  assign m_valid       = r_m_valid;
  assign busy          = (r_state != StIdle);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StLoad;
      StLoad:  w_state_d = StMac;
      StMac:   if (w_last_mac) w_state_d = StOut;
      StOut:   if (m_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch         <= 1'b0;
      r_sample     <= '0;
      r_acc        <= '0;
      r_prod       <= '0;
      r_k          <= '0;
      r_prio_right <= 1'b0;
      r_m_data     <= '0;
      r_m_channel  <= 1'b0;
      r_m_valid    <= 1'b0;
      r_wptr[0]    <= '0;
      r_wptr[1]    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_ch     <= w_grant_right;
            r_sample <= w_grant_right ? s_right_data : s_left_data;
          end
        end
        StLoad: begin
          r_acc  <= '0;
          r_prod <= '0;
          r_k    <= '0;
        end
        StMac: begin
          // Multiplier output is registered; the accumulate lags the product by one cycle.
          r_acc  <= r_acc + w_prod_ext;
          r_prod <= w_prod;
          r_k    <= r_k + 1'b1;
          if (w_last_mac) begin
            r_m_data     <= r_acc + w_prod_ext;
            r_m_channel  <= r_ch;
            r_m_valid    <= 1'b1;
            r_wptr[r_ch] <= r_wptr[r_ch] + 1'b1;
          end
        end
        StOut: begin
          if (m_ready) begin
            r_m_valid    <= 1'b0;
            r_prio_right <= !r_ch;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < TAPS; i++) begin
          r_hist[c][i] <= '0;
        end
      end
    end else if (r_state == StLoad) begin
      r_hist[r_ch][r_wptr[r_ch]] <= r_sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
      end
    end else if (r_state == StIdle && coef_wr_en) begin
      r_coef[coef_wr_addr] <= coef_wr_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler: a reference FIR model predicts each output at the
// input handshake; a negedge monitor pops and compares when the DUT delivers a result.
module tb_fir_mac_scheduler;

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 16;
  localparam int unsigned TAPS  = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned ACC_W = DW + CW + PTR_W;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic signed [DW-1:0] s_left_data;
  logic                 s_left_valid;
  logic                 s_left_ready;
  logic signed [DW-1:0] s_right_data;
  logic                 s_right_valid;
  logic                 s_right_ready;
  logic signed [ACC_W-1:0] m_data;
  logic                 m_channel;
  logic                 m_valid;
  logic                 m_ready;
  logic                 coef_wr_en;
  logic [PTR_W-1:0]     coef_wr_addr;
  logic signed [CW-1:0] coef_wr_data;
  logic                 busy;

  always #5 clk = ~clk;

  fir_mac_scheduler #(
    .DATA_WIDTH(DW),
    .COEF_WIDTH(CW),
    .TAPS      (TAPS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_left_data  (s_left_data),
    .s_left_valid (s_left_valid),
    .s_left_ready (s_left_ready),
    .s_right_data (s_right_data),
    .s_right_valid(s_right_valid),
    .s_right_ready(s_right_ready),
    .m_data       (m_data),
    .m_channel    (m_channel),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .busy         (busy)
  );

  typedef struct {
    bit                      ch;
    logic signed [ACC_W-1:0] data;
  } res_t;

  int errors = 0;
  int checks = 0;

  res_t                    exp_q[$];
  logic signed [ACC_W-1:0] out_data_log[$];
  bit                      out_ch_log[$];
  bit                      grant_log[$];
  res_t                    mon_r;

  int signed m_coef[TAPS];
  int signed m_hist[2][TAPS];
  int        m_wptr[2];

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k]    = 0;
      m_hist[0][k] = 0;
      m_hist[1][k] = 0;
    end
    m_wptr[0] = 0;
    m_wptr[1] = 0;
  endfunction

  function automatic void model_accept(bit ch, logic signed [DW-1:0] x);
    longint sum = 0;
    int     idx;
    res_t   r;
    m_hist[ch][m_wptr[ch]] = x;
    for (int k = 0; k < TAPS; k++) begin
      idx = (m_wptr[ch] - k + TAPS) % TAPS;
      sum += longint'(m_coef[k]) * longint'(m_hist[ch][idx]);
    end
    m_wptr[ch] = (m_wptr[ch] + 1) % TAPS;
    r.ch   = ch;
    r.data = sum[ACC_W-1:0];
    exp_q.push_back(r);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (s_left_valid && s_left_ready) begin
        model_accept(1'b0, s_left_data);
        grant_log.push_back(1'b0);
      end
      if (s_right_valid && s_right_ready) begin
        model_accept(1'b1, s_right_data);
        grant_log.push_back(1'b1);
      end
      if (m_valid && m_ready) begin
        out_data_log.push_back(m_data);
        out_ch_log.push_back(m_channel);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data=%0d ch=%0b, required no output",
                   m_data, m_channel);
        end else begin
          mon_r = exp_q.pop_front();
          if (m_data !== mon_r.data || m_channel !== mon_r.ch) begin
            errors++;
            $display("FAIL scoreboard: got data=%0d ch=%0b, required data=%0d ch=%0b",
                     m_data, m_channel, mon_r.data, mon_r.ch);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    out_data_log.delete();
    out_ch_log.delete();
    grant_log.delete();
  endtask

  task automatic apply_reset();
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_coef(input int addr, input logic signed [CW-1:0] data);
    tick();
    coef_wr_en   = 1'b1;
    coef_wr_addr = addr[PTR_W-1:0];
    coef_wr_data = data;
    m_coef[addr] = data;
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic send(input bit ch, input logic signed [DW-1:0] data);
    int n = 0;
    bit rdy = 1'b0;
    tick();
    if (ch) begin s_right_data = data; s_right_valid = 1'b1; end
    else    begin s_left_data  = data; s_left_valid  = 1'b1; end
    while (!rdy && n < 400) begin
      @(negedge clk);
      n++;
      rdy = ch ? s_right_ready : s_left_ready;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL handshake_timeout: ch=%0b ready=0 after %0d cycles, required 1", ch, n);
    end
    @(posedge clk);
    #1;
    if (ch) s_right_valid = 1'b0;
    else    s_left_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d busy=%0b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    s_left_valid  = 1'b1;
    s_right_valid = 1'b1;
    #2;
    checks += 6;
    if (m_data !== '0)       begin errors++; $display("FAIL rst_m_data: got %0d, required 0", m_data); end
    if (m_channel !== 1'b0)  begin errors++; $display("FAIL rst_m_channel: got %0b, required 0", m_channel); end
    if (m_valid !== 1'b0)    begin errors++; $display("FAIL rst_m_valid: got %0b, required 0", m_valid); end
    if (s_left_ready !== 1'b0)  begin errors++; $display("FAIL rst_left_ready: got %0b, required 0", s_left_ready); end
    if (s_right_ready !== 1'b0) begin errors++; $display("FAIL rst_right_ready: got %0b, required 0", s_right_ready); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    s_left_valid  = 1'b0;
    s_right_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    s_left_valid  = 1'b1;
    s_right_valid = 1'b1;
    #1;
    checks += 2;
    if (s_left_ready !== 1'b1)  begin errors++; $display("FAIL first_tie_left: got %0b, required 1", s_left_ready); end
    if (s_right_ready !== 1'b0) begin errors++; $display("FAIL first_tie_right: got %0b, required 0", s_right_ready); end
    #1;
    s_left_valid  = 1'b0;
    s_right_valid = 1'b0;
  endtask

  task automatic test_impulse();
    logic signed [ACC_W-1:0] e;
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'(k + 1));
    clear_logs();
    send(1'b0, 16'sh0100);
    for (int i = 0; i < TAPS; i++) send(1'b0, 16'sh0000);
    wait_idle();
    checks++;
    if (out_data_log.size() != TAPS + 1) begin
      errors++;
      $display("FAIL impulse_count: got %0d, required %0d", out_data_log.size(), TAPS + 1);
    end else begin
      for (int n = 0; n <= TAPS; n++) begin
        e = (n < TAPS) ? ACC_W'(256 * (n + 1)) : '0;
        checks++;
        if (out_data_log[n] !== e || out_ch_log[n] !== 1'b0) begin
          errors++;
          $display("FAIL impulse[%0d]: got %0d ch=%0b, required %0d ch=0",
                   n, out_data_log[n], out_ch_log[n], e);
        end
      end
    end
  endtask

  task automatic test_latency();
    int n = 0;
    int w = 0;
    tick();
    s_left_data  = 16'sd5;
    s_left_valid = 1'b1;
    while (!s_left_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    #1;
    s_left_valid = 1'b0;
    while (!m_valid && n < 100) begin tick(); n++; end
    checks++;
    if (n != TAPS + 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required %0d", n, TAPS + 2);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: got m_valid=%0b one cycle later, required 0", m_valid);
    end
    wait_idle();
  endtask

  task automatic test_arbitration();
    int n = 0;
    logic signed [ACC_W-1:0] exp_data [6];
    apply_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd1);
    clear_logs();
    exp_data = '{1, 2, 2, 4, 3, 6};
    tick();
    s_left_data   = 16'sd1;
    s_right_data  = 16'sd2;
    s_left_valid  = 1'b1;
    s_right_valid = 1'b1;
    while (grant_log.size() < 6 && n < 400) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    s_left_valid  = 1'b0;
    s_right_valid = 1'b0;
    wait_idle();
    checks++;
    if (grant_log.size() != 6 || out_data_log.size() != 6) begin
      errors++;
      $display("FAIL arb_count: got grants=%0d outputs=%0d, required 6 and 6",
               grant_log.size(), out_data_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks += 2;
        if (grant_log[i] !== bit'(i % 2)) begin
          errors++;
          $display("FAIL arb_grant[%0d]: got %0b, required %0b", i, grant_log[i], i % 2);
        end
        if (out_data_log[i] !== exp_data[i] || out_ch_log[i] !== bit'(i % 2)) begin
          errors++;
          $display("FAIL arb_out[%0d]: got %0d ch=%0b, required %0d ch=%0b",
                   i, out_data_log[i], out_ch_log[i], exp_data[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [ACC_W-1:0] held;
    int  n = 0;
    int  out_before;
    int  grants_before;
    bit  stable_ok = 1'b1;
    bit  busy_ok = 1'b1;
    bit  rdy_ok = 1'b1;
    m_ready = 1'b0;
    send(1'b0, 16'sd100);
    s_right_data  = 16'sd7;
    s_right_valid = 1'b1;
    while (!m_valid && n < 100) begin tick(); n++; end
    held = m_data;
    grants_before = grant_log.size();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_data !== held || m_valid !== 1'b1) stable_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (s_left_ready !== 1'b0 || s_right_ready !== 1'b0) rdy_ok = 1'b0;
    end
    checks += 4;
    if (!stable_ok) begin errors++; $display("FAIL bp_hold: got unstable m_data/m_valid, required stable %0d", held); end
    if (!busy_ok)   begin errors++; $display("FAIL bp_busy: got busy=0 during stall, required 1"); end
    if (!rdy_ok)    begin errors++; $display("FAIL bp_ready: got a ready during stall, required 0"); end
    if (grant_log.size() != grants_before) begin
      errors++;
      $display("FAIL bp_grant: got %0d grants during stall, required 0", grant_log.size() - grants_before);
    end
    out_before = out_data_log.size();
    m_ready = 1'b1;
    n = 0;
    while (!s_right_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!s_right_ready || out_data_log.size() != out_before + 1) begin
      errors++;
      $display("FAIL bp_order: got right_ready=%0b outputs=%0d, required 1 and %0d",
               s_right_ready, out_data_log.size() - out_before, 1);
    end
    @(posedge clk);
    #1;
    s_right_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_coef_write();
    int w = 0;
    for (int k = 0; k < TAPS; k++) begin
      write_coef(k, (k % 3 == 0) ? CW'(-1234 * (k + 1)) : CW'(517 * (k + 1) - 300));
    end
    send(1'b0, -16'sd20000);
    repeat (6) tick();
    coef_wr_en   = 1'b1;
    coef_wr_addr = '0;
    coef_wr_data = 16'sh7FFF;
    tick();
    coef_wr_en = 1'b0;
    wait_idle();
    send(1'b0, 16'sd12345);
    send(1'b1, -16'sd321);
    wait_idle();
    for (int k = 1; k < TAPS; k++) write_coef(k, 16'sd0);
    tick();
    coef_wr_en    = 1'b1;
    coef_wr_addr  = '0;
    coef_wr_data  = 16'sh7FFF;
    m_coef[0]     = 32767;
    s_left_data   = 16'sh7FFF;
    s_left_valid  = 1'b1;
    while (!s_left_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    #1;
    coef_wr_en   = 1'b0;
    s_left_valid = 1'b0;
    wait_idle();
    checks++;
    if (out_data_log.size() == 0 || out_data_log[$] !== 36'sh03FFF0001) begin
      errors++;
      $display("FAIL coef_same_cycle: got %0h, required 3fff0001",
               (out_data_log.size() != 0) ? out_data_log[$] : '0);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    bit spurious = 1'b0;
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'(k + 1));
    send(1'b0, 16'sh0100);
    repeat (5) tick();
    s_right_valid = 1'b1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mac_busy: got %0b, required 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    checks += 4;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL async_m_valid: got %0b, required 0", m_valid); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL async_busy: got %0b, required 0", busy); end
    if (s_left_ready !== 1'b0 || s_right_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_ready: got %0b%0b, required 00", s_left_ready, s_right_ready);
    end
    if (m_data !== '0) begin errors++; $display("FAIL async_m_data: got %0d, required 0", m_data); end
    s_right_valid = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_valid) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin errors++; $display("FAIL spurious_output: got m_valid=1 after reset, required 0"); end
    clear_logs();
    send(1'b0, 16'sh0100);
    wait_idle();
    checks++;
    if (out_data_log.size() != 1 || out_data_log[0] !== '0) begin
      errors++;
      $display("FAIL post_reset_impulse: got %0d outputs first=%0d, required 1 output of 0",
               out_data_log.size(), (out_data_log.size() != 0) ? out_data_log[0] : '0);
    end
    write_coef(0, 16'sd3);
    m_ready = 1'b0;
    send(1'b1, 16'sd300);
    while (!m_valid && n < 100) begin tick(); n++; end
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL out_reached: got m_valid=%0b, required 1", m_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL async_out_drop: got m_valid=%0b, required 0", m_valid); end
    model_reset();
    exp_q.delete();
    m_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
  endtask

  initial begin
    s_left_data   = '0;
    s_left_valid  = 1'b0;
    s_right_data  = '0;
    s_right_valid = 1'b0;
    m_ready       = 1'b1;
    coef_wr_en    = 1'b0;
    coef_wr_addr  = '0;
    coef_wr_data  = '0;
    model_reset();
    #1;
    reset = 1'b1;
    test_reset();
    test_impulse();
    test_latency();
    test_arbitration();
    test_backpressure();
    test_coef_write();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
